// File: rtl/link_pkg.sv
// link_pkg: shared types for the link_switch packet switch.
// Holds header width, FSM state enums, the FIFO entry layout and the rr helper.
package link_pkg;

  localparam int HDR_W = 8;

  typedef enum logic [1:0] {
    HEADER,
    REQ,
    FWD,
    DROP
  } in_state_e;

  typedef enum logic {
    IDLE,
    LOCKED
  } out_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  // Round-robin successor of idx among n ports.
  function automatic int rr_next(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/link_fifo.sv
// link_fifo: synchronous input FIFO of {last, data} entries with occupancy count.
// Ports: clk, reset (sync, high), i_push/i_wdata, i_pop, o_rdata (head), o_count.
module link_fifo
  import link_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  fifo_entry_t            i_wdata,
  input  logic                   i_pop,
  output fifo_entry_t            o_rdata,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  // Fullness is judged on the pre-pop count; a push into a full FIFO is lost.
  assign w_push = i_push && (r_cnt < (AW+1)'(DEPTH));
  assign w_pop  = i_pop && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;

endmodule

// File: rtl/link_switch.sv
// link_switch: N-port byte-stream packet switch; first byte of a packet selects
// the output and is stripped. Per-input FIFO, per-output round-robin with lock.
// Ports: clk, reset (sync, high); in_valid/in_data/in_last/in_busy per input;
// out_valid/out_data/out_last (registered) and out_busy per output.
// Build option LINK_SWITCH_STATS_EN adds fwd_count and drop_count (16b each).
module link_switch
  import link_pkg::*;
#(
  parameter int N_PORTS    = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PORTS-1:0]          in_valid,
  input  logic [N_PORTS*DATA_W-1:0]   in_data,
  input  logic [N_PORTS-1:0]          in_last,
  output logic [N_PORTS-1:0]          in_busy,
  output logic [N_PORTS-1:0]          out_valid,
  output logic [N_PORTS*DATA_W-1:0]   out_data,
  output logic [N_PORTS-1:0]          out_last,
  input  logic [N_PORTS-1:0]          out_busy
`ifdef LINK_SWITCH_STATS_EN
  ,
  output logic [N_PORTS*16-1:0]       fwd_count,
  output logic [N_PORTS*16-1:0]       drop_count
`endif
);

  localparam int IW = $clog2(N_PORTS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fifo_entry_t  w_wdata [N_PORTS];
  fifo_entry_t  w_head  [N_PORTS];
  logic [CW-1:0] w_cnt  [N_PORTS];
  logic [N_PORTS-1:0] w_nempty;
  logic [N_PORTS-1:0] w_bad;
  logic [N_PORTS-1:0] w_pop;
  logic [N_PORTS-1:0] w_opop_in;
  logic [N_PORTS-1:0] w_granted;

  in_state_e r_ist    [N_PORTS];
  in_state_e w_ist_nx [N_PORTS];
  logic [IW-1:0] r_dest [N_PORTS];

  // w_req[o][i]: input i wants output o
  logic [N_PORTS-1:0] w_req [N_PORTS];

  out_state_e r_ost    [N_PORTS];
  out_state_e w_ost_nx [N_PORTS];
  logic [IW-1:0] r_own [N_PORTS];
  logic [IW-1:0] r_rr  [N_PORTS];
  logic [IW-1:0] w_gnt [N_PORTS];
  logic [N_PORTS-1:0] w_any;
  logic [N_PORTS-1:0] w_opop;
  int w_idx;

  logic [N_PORTS-1:0]        r_in_busy;
  logic [N_PORTS-1:0]        r_ov;
  logic [N_PORTS*DATA_W-1:0] r_od;
  logic [N_PORTS-1:0]        r_ol;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_fifo
    assign w_wdata[g] = '{last: in_last[g],
                          data: in_data[g*DATA_W +: DATA_W]};
    link_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (in_valid[g]),
      .i_wdata (w_wdata[g]),
      .i_pop   (w_pop[g]),
      .o_rdata (w_head[g]),
      .o_count (w_cnt[g])
    );
    assign w_nempty[g] = (w_cnt[g] != '0);
    assign w_bad[g]    = (w_head[g].data >= HDR_W'(N_PORTS));
  end

  // Requests and grant visibility, from registered state only.
  always_comb begin
    for (int o = 0; o < N_PORTS; o++) begin
      w_req[o] = '0;
    end
    w_granted = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (r_ist[i] == HEADER && w_nempty[i] && !w_bad[i] &&
            !w_head[i].last && w_head[i].data[IW-1:0] == IW'(o))
          w_req[o][i] = 1'b1;
        if (r_ist[i] == REQ && r_dest[i] == IW'(o))
          w_req[o][i] = 1'b1;
        if (r_ost[o] == LOCKED && r_own[o] == IW'(i))
          w_granted[i] = 1'b1;
      end
    end
  end

  // Output arbitration and payload pops.
  always_comb begin
    w_idx  = 0;
    w_any  = '0;
    w_opop = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      w_gnt[o]    = '0;
      w_ost_nx[o] = r_ost[o];
      for (int k = 0; k < N_PORTS; k++) begin
        w_idx = int'(r_rr[o]) + k;
        if (w_idx >= N_PORTS) w_idx = w_idx - N_PORTS;
        if (!w_any[o] && w_req[o][w_idx]) begin
          w_any[o] = 1'b1;
          w_gnt[o] = IW'(w_idx);
        end
      end
      // Payload only moves once the owner has consumed its header.
      w_opop[o] = (r_ost[o] == LOCKED) && (r_ist[r_own[o]] == FWD) &&
                  w_nempty[r_own[o]] && !out_busy[o];
      unique case (r_ost[o])
        IDLE:    if (w_any[o]) w_ost_nx[o] = LOCKED;
        LOCKED:  if (w_opop[o] && w_head[r_own[o]].last)
                   w_ost_nx[o] = IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_opop_in = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      if (w_opop[o]) w_opop_in[r_own[o]] = 1'b1;
    end
  end

  // Input FSMs.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_ist_nx[i] = r_ist[i];
      unique case (r_ist[i])
        HEADER: if (w_nempty[i]) begin
          if (w_bad[i] || w_head[i].last) begin
            w_pop[i] = 1'b1;
            if (!w_head[i].last) w_ist_nx[i] = DROP;
          end else begin
            w_ist_nx[i] = REQ;
          end
        end
        REQ: if (w_granted[i]) begin
          w_pop[i]    = 1'b1;
          w_ist_nx[i] = FWD;
        end
        FWD: if (w_opop_in[i]) begin
          w_pop[i] = 1'b1;
          if (w_head[i].last) w_ist_nx[i] = HEADER;
        end
        DROP: if (w_nempty[i]) begin
          w_pop[i] = 1'b1;
          if (w_head[i].last) w_ist_nx[i] = HEADER;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        r_ist[i]  <= HEADER;
        r_dest[i] <= '0;
        r_ost[i]  <= IDLE;
        r_own[i]  <= '0;
        r_rr[i]   <= '0;
      end
      r_in_busy <= '0;
      r_ov      <= '0;
      r_od      <= '0;
      r_ol      <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        r_ist[i]     <= w_ist_nx[i];
        r_in_busy[i] <= (w_cnt[i] >= CW'(FIFO_DEPTH - 1));
        if (r_ist[i] == HEADER && w_ist_nx[i] == REQ)
          r_dest[i] <= w_head[i].data[IW-1:0];
      end
      for (int o = 0; o < N_PORTS; o++) begin
        r_ost[o] <= w_ost_nx[o];
        if (r_ost[o] == IDLE && w_any[o]) begin
          r_own[o] <= w_gnt[o];
          r_rr[o]  <= IW'(rr_next(int'(w_gnt[o]), N_PORTS));
        end
        r_ov[o] <= w_opop[o];
        if (w_opop[o]) begin
          r_od[o*DATA_W +: DATA_W] <= w_head[r_own[o]].data;
          r_ol[o]                  <= w_head[r_own[o]].last;
        end
      end
    end
  end

  assign in_busy   = r_in_busy;
  assign out_valid = r_ov;
  assign out_data  = r_od;
  assign out_last  = r_ol;

`ifdef LINK_SWITCH_STATS_EN
  logic [15:0] r_fwd  [N_PORTS];
  logic [15:0] r_drop [N_PORTS];
  logic [N_PORTS-1:0] w_ovf;
  logic [N_PORTS-1:0] w_hdrop;

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      w_ovf[i]   = in_valid[i] && (w_cnt[i] == CW'(FIFO_DEPTH));
      w_hdrop[i] = (r_ist[i] == HEADER) && w_nempty[i] && w_bad[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        r_fwd[i]  <= '0;
        r_drop[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (w_opop[i] && w_head[r_own[i]].last) r_fwd[i] <= r_fwd[i] + 16'd1;
        r_drop[i] <= r_drop[i] + 16'(w_hdrop[i]) + 16'(w_ovf[i]);
      end
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_stats
    assign fwd_count[g*16 +: 16]  = r_fwd[g];
    assign drop_count[g*16 +: 16] = r_drop[g];
  end
`endif

endmodule

// File: tb/tb_link_switch.sv
// tb_link_switch: self-checking bench for link_switch (4 ports, 16-deep FIFOs).
// Directed scenarios plus a randomized run against a packet-level scoreboard.
module tb_link_switch;

  localparam int NP = 4;
  localparam int FD = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NP-1:0]   in_valid = '0;
  logic [NP-1:0]   in_last = '0;
  logic [NP*8-1:0] in_data = '0;
  logic [NP-1:0]   in_busy;
  logic [NP-1:0]   out_valid;
  logic [NP-1:0]   out_last;
  logic [NP*8-1:0] out_data;
  logic [NP-1:0]   out_busy = '0;
`ifdef LINK_SWITCH_STATS_EN
  logic [NP*16-1:0] fwd_count;
  logic [NP*16-1:0] drop_count;
`endif

  link_switch #(.N_PORTS(NP), .FIFO_DEPTH(FD), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_busy   (in_busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_busy  (out_busy)
`ifdef LINK_SWITCH_STATS_EN
    ,
    .fwd_count  (fwd_count),
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    int         p;
    logic       l;
    logic [7:0] d;
  } ev_t;

  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  bit rnd_gap = 0;
  logic [NP-1:0] busy_drv = '0;
  logic [8:0] sq [NP][$];
  logic [8:0] exq [NP*NP][$];
  ev_t log_q [$];

  // One clock: drive queued bytes (honouring in_busy), then log outputs.
  task automatic step();
    logic [8:0] b;
    for (int i = 0; i < NP; i++) begin
      if (sq[i].size() > 0 && !in_busy[i] &&
          !(rnd_gap && $urandom_range(3) == 0)) begin
        b = sq[i].pop_front();
        in_valid[i] = 1'b1;
        in_last[i] = b[8];
        in_data[8*i +: 8] = b[7:0];
      end else begin
        in_valid[i] = 1'b0;
        in_last[i] = 1'b0;
      end
    end
    out_busy = busy_drv;
    @(posedge clk);
    #1;
    cyc_n++;
    for (int o = 0; o < NP; o++)
      if (out_valid[o])
        log_q.push_back('{cyc_n, o, out_last[o], out_data[8*o +: 8]});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = '0;
    in_last = '0;
    busy_drv = '0;
    out_busy = '0;
    rnd_gap = 0;
    for (int i = 0; i < NP; i++) sq[i].delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    log_q.delete();
    cyc_n = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== '0) begin
      errors++;
      $display("FAIL reset_out_valid got=%h exp=0", out_valid);
    end
    checks++;
    if (out_data !== '0 || out_last !== '0) begin
      errors++;
      $display("FAIL reset_out_data got=%h/%h exp=0", out_data, out_last);
    end
    checks++;
    if (in_busy !== '0) begin
      errors++;
      $display("FAIL reset_in_busy got=%h exp=0", in_busy);
    end
  endtask

  task automatic test_basic();
    do_reset();
    sq[0] = '{9'h001, 9'h0AA, 9'h1BB};
    run(12);
    checks++;
    if (log_q.size() != 2) begin
      errors++;
      $display("FAIL basic_count got=%0d exp=2", log_q.size());
    end else begin
      checks++;
      if (log_q[0].t != 4 || log_q[0].p != 1 ||
          log_q[0].d !== 8'hAA || log_q[0].l !== 1'b0) begin
        errors++;
        $display("FAIL basic_first got=t%0d p%0d %h l%b exp=t4 p1 aa l0",
                 log_q[0].t, log_q[0].p, log_q[0].d, log_q[0].l);
      end
      checks++;
      if (log_q[1].t != 5 || log_q[1].p != 1 ||
          log_q[1].d !== 8'hBB || log_q[1].l !== 1'b1) begin
        errors++;
        $display("FAIL basic_second got=t%0d p%0d %h l%b exp=t5 p1 bb l1",
                 log_q[1].t, log_q[1].p, log_q[1].d, log_q[1].l);
      end
    end
  endtask

  task automatic test_arbitration();
    logic [7:0] ed [6];
    ed = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13};
    do_reset();
    sq[0] = '{9'h002, 9'h001, 9'h002, 9'h103};
    sq[1] = '{9'h002, 9'h011, 9'h012, 9'h113};
    run(30);
    checks++;
    if (log_q.size() != 6) begin
      errors++;
      $display("FAIL arb_count got=%0d exp=6", log_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (log_q[k].p != 2 || log_q[k].d !== ed[k] ||
            log_q[k].l !== (k == 2 || k == 5)) begin
          errors++;
          $display("FAIL arb_byte%0d got=p%0d %h l%b exp=p2 %h l%b", k,
                   log_q[k].p, log_q[k].d, log_q[k].l, ed[k],
                   (k == 2 || k == 5));
        end
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    sq[0] = '{9'h007, 9'h021, 9'h022, 9'h023, 9'h024, 9'h125};
    run(15);
    checks++;
    if (log_q.size() != 0) begin
      errors++;
      $display("FAIL drop_silent got=%0d bytes exp=0", log_q.size());
    end
`ifdef LINK_SWITCH_STATS_EN
    checks++;
    if (drop_count[15:0] !== 16'd1) begin
      errors++;
      $display("FAIL drop_count got=%0d exp=1", drop_count[15:0]);
    end
`endif
    sq[0] = '{9'h000, 9'h15A};
    run(10);
    checks++;
    if (log_q.size() != 1 || log_q[0].p != 0 ||
        log_q[0].d !== 8'h5A || log_q[0].l !== 1'b1) begin
      errors++;
      $display("FAIL drop_recover got=%0d bytes exp=1 byte 5a on p0",
               log_q.size());
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    int prev;
    bit seen;
    do_reset();
    busy_drv = 4'b0010;
    sq[0].push_back(9'h001);
    for (int k = 0; k < 19; k++)
      sq[0].push_back({k == 18, 8'(8'hB0 + k)});
    prev = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      cnt = (20 - sq[0].size()) - ((cyc_n >= 3) ? 1 : 0);
      if (in_busy[0]) begin
        seen = 1;
        checks++;
        if (prev != 15) begin
          errors++;
          $display("FAIL bp_busy_point got_prev_count=%0d exp=15", prev);
        end
      end
      prev = cnt;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_busy_rise got=0 exp=1 within 40 cycles");
    end
    run(3);
    checks++;
    if (log_q.size() != 0) begin
      errors++;
      $display("FAIL bp_hold got=%0d bytes exp=0", log_q.size());
    end
    busy_drv = '0;
    for (int k = 0; k < 80 && (log_q.size() < 19 || sq[0].size() > 0); k++)
      step();
    run(3);
    checks++;
    if (log_q.size() != 19) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=19", log_q.size());
    end else begin
      for (int k = 0; k < 19; k++) begin
        checks++;
        if (log_q[k].p != 1 || log_q[k].d !== 8'(8'hB0 + k) ||
            log_q[k].l !== (k == 18)) begin
          errors++;
          $display("FAIL bp_byte%0d got=p%0d %h exp=p1 %h", k,
                   log_q[k].p, log_q[k].d, 8'(8'hB0 + k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sq[0] = '{9'h001, 9'h061, 9'h062, 9'h063, 9'h064, 9'h065,
              9'h066, 9'h067, 9'h068, 9'h069, 9'h06A};
    run(6);
    checks++;
    if (log_q.size() == 0) begin
      errors++;
      $display("FAIL rmid_started got=0 bytes exp>0");
    end
    reset = 1'b1;
    in_valid = '0;
    in_last = '0;
    sq[0].delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== '0 || in_busy !== '0) begin
      errors++;
      $display("FAIL rmid_cleared got=%h/%h exp=0/0", out_valid, in_busy);
    end
    log_q.delete();
    cyc_n = 0;
    sq[0] = '{9'h000, 9'h155};
    run(15);
    checks++;
    if (log_q.size() != 1 || log_q[0].p != 0 ||
        log_q[0].d !== 8'h55 || log_q[0].l !== 1'b1) begin
      errors++;
      $display("FAIL rmid_newpkt got=%0d bytes exp=1 byte 55 on p0",
               log_q.size());
    end
  endtask

  task automatic test_loopback();
`ifdef LINK_SWITCH_STATS_EN
    logic [15:0] f0;
`endif
    do_reset();
`ifdef LINK_SWITCH_STATS_EN
    f0 = fwd_count[31:16];
`endif
    sq[1] = '{9'h001, 9'h13C};
    run(10);
    checks++;
    if (log_q.size() != 1 || log_q[0].p != 1 || log_q[0].t != 4 ||
        log_q[0].d !== 8'h3C || log_q[0].l !== 1'b1) begin
      errors++;
      $display("FAIL loopback got=%0d bytes exp=1 byte 3c on p1 at t4",
               log_q.size());
    end
`ifdef LINK_SWITCH_STATS_EN
    checks++;
    if (fwd_count[31:16] !== 16'(f0 + 16'd1)) begin
      errors++;
      $display("FAIL loop_fwd_count got=%0d exp=%0d", fwd_count[31:16],
               f0 + 16'd1);
    end
`endif
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < NP; i++) s += sq[i].size();
    for (int j = 0; j < NP * NP; j++) s += exq[j].size();
    return s;
  endfunction

  // Payload bytes carry their source input in bits 7:6, so the scoreboard
  // can pick the right per-(input,output) queue and spot interleaving.
  task automatic test_random();
    int cur [NP];
    int guard;
    int src;
    int dst;
    int len;
    logic [8:0] e;
    ev_t ev;
    do_reset();
    for (int o = 0; o < NP; o++) cur[o] = -1;
    for (int j = 0; j < NP * NP; j++) exq[j].delete();
    for (int i = 0; i < NP; i++) begin
      for (int p = 0; p < 25; p++) begin
        dst = ($urandom_range(7) == 0) ? 4 + $urandom_range(251)
                                       : $urandom_range(NP - 1);
        len = $urandom_range(5);
        sq[i].push_back({len == 0, 8'(dst)});
        for (int k = 0; k < len; k++) begin
          e = {k == len - 1, 2'(i), 6'($urandom)};
          sq[i].push_back(e);
          if (dst < NP) exq[i*NP + dst].push_back(e);
        end
      end
    end
    rnd_gap = 1;
    guard = 0;
    while (guard < 4000 && pending() > 0) begin
      busy_drv = 4'($urandom) & 4'($urandom);
      step();
      guard++;
      while (log_q.size() > 0) begin
        ev = log_q.pop_front();
        src = (cur[ev.p] >= 0) ? cur[ev.p] : int'(ev.d[7:6]);
        checks++;
        if (exq[src*NP + ev.p].size() == 0) begin
          errors++;
          $display("FAIL rnd_extra p%0d got=%h exp=none from in%0d",
                   ev.p, ev.d, src);
        end else begin
          e = exq[src*NP + ev.p].pop_front();
          if ({ev.l, ev.d} !== e) begin
            errors++;
            $display("FAIL rnd_byte p%0d got=%h l%b exp=%h l%b", ev.p,
                     ev.d, ev.l, e[7:0], e[8]);
          end
        end
        cur[ev.p] = ev.l ? -1 : src;
      end
    end
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL rnd_drain got=%0d pending exp=0", pending());
    end
    busy_drv = '0;
    rnd_gap = 0;
    run(5);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arbitration();
    test_drop();
    test_backpressure();
    test_reset_mid();
    test_loopback();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
